avl_mem_responder: RTL and testbench

Avalon-MM slave that terminates the single shared bus driven by the instruction/data bus arbiter. Models a word-organised memory with a fixed, parameterised number of wait states and per-byte write enables. Used as the memory endpoint in the core testbench and as the on-chip RAM behind the arbiter. It is a responder only: it never initiates transfers.

---
 rtl/avl_mem_responder.sv | 143 ++++++++++++++
 tb/tb_avl_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder: word-organised RAM with a fixed wait-state count,
// per-byte write enables and a sticky protocol-error flag.
module avl_mem_responder #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_CYCLES = 2,
   parameter     INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] avl_address,
   input  logic        avl_read,
   input  logic        avl_write,
   input  logic [31:0] avl_writedata,
   input  logic [3:0]  avl_byteenable,
   output logic [31:0] avl_readdata,
   output logic        avl_waitrequest,
   output logic        err
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [31:2]    hold_addr_q, hold_addr_d;
   logic           hold_wr_q, hold_wr_d;
   logic [31:0]    hold_wdata_q, hold_wdata_d;
   logic [3:0]     hold_be_q, hold_be_d;
   logic           err_q, err_d;
   logic           wait_q, wait_d;
   logic [31:0]    rdata_q;

   logic                 rd_load;
   logic                 mem_we;
   logic                 hold_in_range;
   logic [ADDR_BITS-1:0] hold_idx;

   logic [31:0] mem [DEPTH];

   // Byte offset within a word carries no meaning for a word-organised memory.
   logic unused_addr_bits;
   assign unused_addr_bits = ^avl_address[1:0];

   assign hold_in_range = (hold_addr_q[31:ADDR_BITS+2] == '0);
   assign hold_idx      = hold_addr_q[ADDR_BITS+1:2];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_addr_d  = hold_addr_q;
      hold_wr_d    = hold_wr_q;
      hold_wdata_d = hold_wdata_q;
      hold_be_d    = hold_be_q;
      err_d        = err_q;
      wait_d       = 1'b1;
      rd_load      = 1'b0;
      mem_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (avl_read || avl_write) begin
               // A read+write collision is resolved as a write and flagged.
               hold_addr_d  = avl_address[31:2];
               hold_wr_d    = avl_write;
               hold_wdata_d = avl_writedata;
               hold_be_d    = avl_byteenable;
               if (avl_read && avl_write) begin
                  err_d = 1'b1;
               end
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_DONE;
               wait_d  = 1'b0;
               rd_load = !hold_wr_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            mem_we  = hold_wr_q && hold_in_range;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         hold_addr_q  <= '0;
         hold_wr_q    <= 1'b0;
         hold_wdata_q <= '0;
         hold_be_q    <= '0;
         err_q        <= 1'b0;
         wait_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_addr_q  <= hold_addr_d;
         hold_wr_q    <= hold_wr_d;
         hold_wdata_q <= hold_wdata_d;
         hold_be_q    <= hold_be_d;
         err_q        <= err_d;
         wait_q       <= wait_d;
      end
   end

   // Memory array is never reset; a reset landing on DONE suppresses the commit.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (hold_be_q[i]) begin
               mem[hold_idx][8*i +: 8] <= hold_wdata_q[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_load) begin
         rdata_q <= hold_in_range ? mem[hold_idx] : 32'h0;
      end
   end

   assign avl_readdata    = rdata_q;
   assign avl_waitrequest = wait_q;
   assign err             = err_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed bench for avl_mem_responder: a WAIT_CYCLES=2 instance driven from a
// vector table plus hand sequences, and a WAIT_CYCLES=0 instance on the same inputs.
module tb_avl_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic [31:0] rdata2, rdata0;
   logic        wait2, wait0;
   logic        err2, err0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   avl_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
      .clk             (clk),
      .rst             (rst),
      .avl_address     (address),
      .avl_read        (read),
      .avl_write       (write),
      .avl_writedata   (wdata),
      .avl_byteenable  (be),
      .avl_readdata    (rdata2),
      .avl_waitrequest (wait2),
      .err             (err2)
   );

   avl_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
      .clk             (clk),
      .rst             (rst),
      .avl_address     (address),
      .avl_read        (read),
      .avl_write       (write),
      .avl_writedata   (wdata),
      .avl_byteenable  (be),
      .avl_readdata    (rdata0),
      .avl_waitrequest (wait0),
      .err             (err0)
   );

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Presents a request in an IDLE cycle, holds it until accepted, then leaves one idle cycle.
   task automatic xfer(input bit sel0, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rdv, output logic err_next);
      logic w;
      read = rd; write = wr; address = a; wdata = d; be = b;
      lat = 0;
      err_next = 1'b0;
      w = 1'b1;
      while (w && lat < 40) begin
         step;
         lat++;
         if (lat == 1) err_next = sel0 ? err0 : err2;
         w = sel0 ? wait0 : wait2;
      end
      rdv = sel0 ? rdata0 : rdata2;
      $display("xfer dut%0d rd=%0b wr=%0b addr=%h data=%h be=%h lat=%0d rdata=%h",
               sel0 ? 0 : 2, rd, wr, a, d, b, lat, rdv);
      read = 1'b0; write = 1'b0;
      step;
   endtask

   initial begin
      int          lat;
      int          n;
      logic [31:0] rv;
      logic [31:0] last_rd;
      logic        en;

      vecs[0]  = '{"wr_cafe",   1'b0, 1'b1, 32'h10,       32'hCAFEBABE, 4'hF, 32'h0};
      vecs[1]  = '{"rd_cafe",   1'b1, 1'b0, 32'h10,       32'h0,        4'hF, 32'hCAFEBABE};
      vecs[2]  = '{"rd_lowbits",1'b1, 1'b0, 32'h13,       32'h0,        4'hF, 32'hCAFEBABE};
      vecs[3]  = '{"wr_full20", 1'b0, 1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0};
      vecs[4]  = '{"wr_part20", 1'b0, 1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0};
      vecs[5]  = '{"rd_part20", 1'b1, 1'b0, 32'h20,       32'h0,        4'hF, 32'h11BB33DD};
      vecs[6]  = '{"wr_word0",  1'b0, 1'b1, 32'h0,        32'h00C0FFEE, 4'hF, 32'h0};
      vecs[7]  = '{"wr_oor",    1'b0, 1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0};
      vecs[8]  = '{"rd_oor",    1'b1, 1'b0, 32'h1000,     32'h0,        4'hF, 32'h0};
      vecs[9]  = '{"rd_word0",  1'b1, 1'b0, 32'h0,        32'h0,        4'hF, 32'h00C0FFEE};
      vecs[10] = '{"wr_30",     1'b0, 1'b1, 32'h30,       32'h13572468, 4'hF, 32'h0};
      vecs[11] = '{"wr_be0",    1'b0, 1'b1, 32'h30,       32'hFFFFFFFF, 4'h0, 32'h0};
      vecs[12] = '{"rd_30_be0", 1'b1, 1'b0, 32'h30,       32'h0,        4'h0, 32'h13572468};
      vecs[13] = '{"wr_top",    1'b0, 1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, 32'h0};
      vecs[14] = '{"wr_hi_oor", 1'b0, 1'b1, 32'hFFFFFFFC, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[15] = '{"rd_top",    1'b1, 1'b0, 32'hFFC,      32'h0,        4'hF, 32'h0BADF00D};

      rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0; be = '0;
      step; step;
      rst = 1'b0;
      chk("rst_wait2", {31'b0, wait2}, 32'h1);
      chk("rst_rdata2", rdata2, 32'h0);
      chk("rst_err2", {31'b0, err2}, 32'h0);
      chk("rst_wait0", {31'b0, wait0}, 32'h1);
      chk("rst_rdata0", rdata0, 32'h0);

      // Table: every transfer accepts WAIT_CYCLES+2 = 4 cycles after presentation.
      last_rd = 32'h0;
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rv, en);
         if (vecs[i].rd) last_rd = vecs[i].exp_rd;
         chk({vecs[i].name, "_lat"}, 32'(lat), 32'd4);
         chk({vecs[i].name, "_rdata"}, rv, last_rd);
         chk({vecs[i].name, "_err"}, {31'b0, err2}, 32'h0);
      end

      // Simultaneous read+write: treated as a write, err sticky from the next cycle.
      xfer(1'b0, 1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, lat, rv, en);
      chk("sim_err_next", {31'b0, en}, 32'h1);
      chk("sim_lat", 32'(lat), 32'd4);
      chk("sim_rdata_held", rv, last_rd);
      xfer(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, rv, en);
      chk("sim_rd8", rv, 32'h5A5A5A5A);
      step; step;
      chk("sim_err_sticky", {31'b0, err2}, 32'h1);

      // Reset while in COUNT aborts the pending write.
      xfer(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 4'hF, lat, rv, en);
      read = 1'b0; write = 1'b1; address = 32'h4; wdata = 32'h12345678; be = 4'hF;
      step;
      rst = 1'b1; write = 1'b0;
      step;
      rst = 1'b0;
      $display("reset in COUNT: wait=%0b rdata=%h err=%0b", wait2, rdata2, err2);
      chk("rstc_wait", {31'b0, wait2}, 32'h1);
      chk("rstc_rdata", rdata2, 32'h0);
      chk("rstc_err", {31'b0, err2}, 32'h0);
      xfer(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat, rv, en);
      chk("rstc_rd4_lat", 32'(lat), 32'd4);
      chk("rstc_rd4", rv, 32'h0);

      // Reset during the DONE cycle must also drop the commit.
      read = 1'b0; write = 1'b1; address = 32'h4; wdata = 32'h12345678; be = 4'hF;
      n = 0;
      do begin
         step;
         n++;
      end while (wait2 && n < 40);
      chk("rstd_acc_lat", 32'(n), 32'd4);
      rst = 1'b1; write = 1'b0;
      step;
      rst = 1'b0;
      $display("reset in DONE: wait=%0b rdata=%h", wait2, rdata2);
      chk("rstd_wait", {31'b0, wait2}, 32'h1);
      xfer(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat, rv, en);
      chk("rstd_rd4", rv, 32'h0);

      // WAIT_CYCLES=0 instance; let both instances drain first.
      step; step; step; step;
      xfer(1'b1, 1'b0, 1'b1, 32'h0, 32'h1, 4'hF, lat, rv, en);
      chk("w0_wr0_lat", 32'(lat), 32'd2);
      xfer(1'b1, 1'b0, 1'b1, 32'h4, 32'h77, 4'hF, lat, rv, en);
      chk("w0_wr4_lat", 32'(lat), 32'd2);
      read = 1'b1; write = 1'b0; address = 32'h0; be = 4'hF;
      step;
      chk("w0_t1_wait", {31'b0, wait0}, 32'h1);
      address = 32'h4;
      step;
      $display("w0 T2: wait=%0b rdata=%h", wait0, rdata0);
      chk("w0_t2_wait", {31'b0, wait0}, 32'h0);
      chk("w0_t2_rdata", rdata0, 32'h1);
      step;
      chk("w0_t3_wait", {31'b0, wait0}, 32'h1);
      step;
      chk("w0_t4_wait", {31'b0, wait0}, 32'h1);
      step;
      $display("w0 T5: wait=%0b rdata=%h", wait0, rdata0);
      chk("w0_t5_wait", {31'b0, wait0}, 32'h0);
      chk("w0_t5_rdata", rdata0, 32'h77);
      read = 1'b0;
      step;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
